// File: rtl/stage_pipe_reg.sv
// Parametrised inter-stage pipeline register: a WIDTH-bit, DEPTH-stage delay line with
// per-stage valid bits, flush/stall handling, occupancy and a saturating bubble counter.
module stage_pipe_reg #(
    parameter int WIDTH          = 142,
    parameter int DEPTH          = 1,
    parameter int STAGE          = 4,
    parameter int ZERO_ON_BUBBLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [5:0]       stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       occupancy,
    output logic [31:0]      bubble_cnt
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [31:0]      cnt_q;

    logic             own_stall;
    logic             down_stall;
    logic             shift_en;
    logic             bubble;
    logic             stage0_valid;
    logic [WIDTH-1:0] stage0_data;

    // Only two bits of the global stall bus belong to this register.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall;

    assign own_stall  = stall[STAGE];
    assign down_stall = stall[STAGE+1];
    assign bubble     = own_stall && !down_stall;
    assign shift_en   = !own_stall || !down_stall;

    always_comb begin
        stage0_valid = 1'b0;
        stage0_data  = '0;
        if (!own_stall) begin
            stage0_valid = in_valid;
            if (in_valid || (ZERO_ON_BUBBLE == 0)) begin
                stage0_data = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (shift_en) begin
            for (int k = 1; k < DEPTH; k++) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
            end
            v[0] <= stage0_valid;
            d[0] <= stage0_data;
            if (bubble && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Popcount of the valid bits; the line is at most 4 deep so 3 bits suffice.
    always_comb begin
        occupancy = 3'd0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + {2'b00, v[k]};
        end
    end

    assign out_valid  = v[DEPTH-1];
    assign out_data   = d[DEPTH-1];
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Directed bench for stage_pipe_reg: three 8-bit instances (DEPTH=2, DEPTH=1 zeroing,
// DEPTH=1 non-zeroing) share one stimulus stream; each scenario checks the relevant one.
module tb_stage_pipe_reg;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [5:0] stall;
    logic       in_valid;
    logic [7:0] in_data;

    logic        d2_valid, d1_valid, d0_valid;
    logic [7:0]  d2_data,  d1_data,  d0_data;
    logic [2:0]  d2_occ,   d1_occ,   d0_occ;
    logic [31:0] d2_cnt,   d1_cnt,   d0_cnt;

    int testsRun;
    int testsFailed;

    stage_pipe_reg #(.WIDTH(8), .DEPTH(2), .STAGE(4), .ZERO_ON_BUBBLE(1)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(d2_valid), .out_data(d2_data), .occupancy(d2_occ), .bubble_cnt(d2_cnt)
    );

    stage_pipe_reg #(.WIDTH(8), .DEPTH(1), .STAGE(4), .ZERO_ON_BUBBLE(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(d1_valid), .out_data(d1_data), .occupancy(d1_occ), .bubble_cnt(d1_cnt)
    );

    stage_pipe_reg #(.WIDTH(8), .DEPTH(1), .STAGE(4), .ZERO_ON_BUBBLE(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(d0_valid), .out_data(d0_data), .occupancy(d0_occ), .bubble_cnt(d0_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the rising edge act, then settle on the falling edge.
    task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s,
                                 input logic iv, input logic [7:0] id);
        rst      = r;
        flush    = f;
        stall    = s;
        in_valid = iv;
        in_data  = id;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    localparam logic [5:0] NOSTALL = 6'b000000;
    localparam logic [5:0] BUBBLE  = 6'b010000;
    localparam logic [5:0] HOLD    = 6'b110000;

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Reset for two cycles
        applyStimulus(1'b1, 1'b0, NOSTALL, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, NOSTALL, 1'b1, 8'hEE);
        checkOutput("rst_valid", 32'(d2_valid), 32'd0);
        checkOutput("rst_data",  32'(d2_data),  32'd0);
        checkOutput("rst_occ",   32'(d2_occ),   32'd0);
        checkOutput("rst_cnt",   d2_cnt,        32'd0);

        // Fill the DEPTH=2 line
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h11);
        checkOutput("fill1_valid", 32'(d2_valid), 32'd0);
        checkOutput("fill1_occ",   32'(d2_occ),   32'd1);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h22);
        checkOutput("fill2_valid", 32'(d2_valid), 32'd1);
        checkOutput("fill2_data",  32'(d2_data),  32'h11);
        checkOutput("fill2_occ",   32'(d2_occ),   32'd2);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h33);
        checkOutput("fill3_data",  32'(d2_data),  32'h22);
        checkOutput("fill3_occ",   32'(d2_occ),   32'd2);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b0, 8'h00);
        checkOutput("fill4_data",  32'(d2_data),  32'h33);
        checkOutput("fill4_occ",   32'(d2_occ),   32'd1);
        checkOutput("d1_idle_valid", 32'(d1_valid), 32'd0);

        // Bubble insert on the DEPTH=1 line
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'hAB);
        checkOutput("bub_pre_valid", 32'(d1_valid), 32'd1);
        checkOutput("bub_pre_data",  32'(d1_data),  32'hAB);
        applyStimulus(1'b0, 1'b0, BUBBLE, 1'b1, 8'hCC);
        checkOutput("bub_valid", 32'(d1_valid), 32'd0);
        checkOutput("bub_data",  32'(d1_data),  32'h00);
        checkOutput("bub_cnt",   d1_cnt,        32'd1);
        checkOutput("bub_d2_data", 32'(d2_data), 32'hAB);
        checkOutput("bub_d2_cnt",  d2_cnt,       32'd1);

        // Hold on the DEPTH=2 line
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h02);
        checkOutput("hold_pre_data", 32'(d2_data), 32'h01);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, HOLD, 1'b1, 8'h03);
            checkOutput("hold_data", 32'(d2_data), 32'h01);
            checkOutput("hold_occ",  32'(d2_occ),  32'd2);
        end
        checkOutput("hold_cnt", d2_cnt, 32'd1);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h03);
        checkOutput("rel1_data", 32'(d2_data), 32'h02);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b0, 8'h00);
        checkOutput("rel2_data",  32'(d2_data),  32'h03);
        checkOutput("rel2_valid", 32'(d2_valid), 32'd1);

        // Flush beats a simultaneous bubble
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h44);
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b1, 8'h55);
        checkOutput("fl_pre_occ", 32'(d2_occ), 32'd2);
        applyStimulus(1'b0, 1'b1, BUBBLE, 1'b1, 8'h66);
        checkOutput("fl_valid", 32'(d2_valid), 32'd0);
        checkOutput("fl_data",  32'(d2_data),  32'h00);
        checkOutput("fl_occ",   32'(d2_occ),   32'd0);
        checkOutput("fl_cnt",   d2_cnt,        32'd1);

        // Invalid advance: payload kept only when not zeroing
        applyStimulus(1'b0, 1'b0, NOSTALL, 1'b0, 8'h5A);
        checkOutput("zob0_valid", 32'(d0_valid), 32'd0);
        checkOutput("zob0_data",  32'(d0_data),  32'h5A);
        checkOutput("zob1_data",  32'(d1_data),  32'h00);

        // Counter saturation via backdoor preload
        force u1.cnt_q = 32'hFFFF_FFFE;
        #1;
        release u1.cnt_q;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, BUBBLE, 1'b0, 8'h00);
            checkOutput("sat_cnt", d1_cnt, 32'hFFFF_FFFF);
        end
        checkOutput("sat_d2_cnt", d2_cnt, 32'd4);

        // Reset wins over flush and clears the counter
        applyStimulus(1'b1, 1'b1, BUBBLE, 1'b1, 8'h77);
        checkOutput("rst2_cnt",   d1_cnt,        32'd0);
        checkOutput("rst2_d2cnt", d2_cnt,        32'd0);
        checkOutput("rst2_occ",   32'(d2_occ),   32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
